debug_host_master: RTL and testbench

- Initiator side of the core's debug access port. It drives `debug_enable`, `debug_addr`, `debug_read`, `debug_write` and `debug_write_data`, and consumes `debug_read_data` and `debug_ready`.
- Accepts queued read/write commands from a host-side controller (JTAG/UART bridge) over a valid/ready command channel.
- Performs one debug-bus transaction per command, with a ready timeout.
- Returns each result over a valid/ready response channel, strictly in command order.

---
 rtl/debug_pkg.sv | 26 ++
 rtl/debug_cmd_fifo.sv | 51 +++++
 rtl/debug_host_master.sv | 160 ++++++++++++++++
 tb/tb_debug_host_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug access port initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package debug_pkg;

   localparam int DEBUG_ADDR_W  = 12;
   localparam int DEBUG_DATA_W  = 32;
   // Address bit that selects CSR space (1) versus the GPR file (0).
   localparam int DEBUG_CSR_BIT = DEBUG_ADDR_W - 1;

   typedef enum logic [2:0] {
      IDLE,
      ENABLE,
      ISSUE,
      WAIT,
      RESP
   } dbg_state_t;

   // Command as queued by the host-side controller, at the default bus widths.
   typedef struct packed {
      logic                    write;
      logic [DEBUG_ADDR_W-1:0] addr;
      logic [DEBUG_DATA_W-1:0] wdata;
   } dbg_cmd_t;

endpackage

// File: rtl/debug_cmd_fifo.sv
// Show-ahead synchronous FIFO; head is the registered oldest entry.
// Latency: a push is visible at head the cycle after it is accepted.
// Backpressure: push ignored when full, pop ignored when empty; both may occur together.
module debug_cmd_fifo #(
   parameter int WIDTH = 45,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // Storage write; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointer advance on accepted push / pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/debug_host_master.sv
// Debug-port initiator: queued read/write commands, one bus transaction each, in-order responses.
// Latency: idle push -> ENABLE next cycle -> strobe -> response; back-to-back one per 2 cycles.
// Backpressure: cmd_ready = !fifo_full; a stalled response holds the FSM in RESP and the bus idle.
module debug_host_master
   import debug_pkg::*;
#(
   parameter int ADDR_W     = DEBUG_ADDR_W,
   parameter int DATA_W     = DEBUG_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_write,
   output logic              rsp_error,
   output logic              debug_enable,
   output logic [ADDR_W-1:0] debug_addr,
   output logic              debug_read,
   output logic              debug_write,
   output logic [DATA_W-1:0] debug_write_data,
   input  logic [DATA_W-1:0] debug_read_data,
   input  logic              debug_ready,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // Same layout as dbg_cmd_t, but sized by this instance's parameters.
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   cmd_t              push_cmd;
   cmd_t              head_cmd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   dbg_state_t        state;
   dbg_state_t        state_nxt;

   logic              op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              timeout_hit;

   assign push_cmd  = {cmd_write, cmd_addr, cmd_wdata};
   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;

   debug_cmd_fifo #(
      .WIDTH (1 + ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .head      (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // The WAIT cycle whose increment would bring the counter to TIMEOUT ends the wait.
   assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an incoming push wakes IDLE directly to save a cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty || push) state_nxt = ENABLE;
         ENABLE:  state_nxt = ISSUE;
         ISSUE:   state_nxt = debug_ready ? RESP : WAIT;
         WAIT:    if (debug_ready || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs plus the FIFO pop that loads the next command.
   always_comb begin
      debug_enable = (state != IDLE);
      debug_read   = (state == ISSUE) && !op_q;
      debug_write  = (state == ISSUE) && op_q;
      rsp_valid    = (state == RESP);
      busy         = !fifo_empty || (state != IDLE);
      pop          = (state == ENABLE) || ((state == RESP) && rsp_ready && !fifo_empty);
   end

   // Command latch, timeout counter and response capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (pop) begin
            op_q    <= head_cmd.write;
            addr_q  <= head_cmd.addr;
            wdata_q <= head_cmd.wdata;
         end
         case (state)
            ISSUE: begin
               cnt_q <= CNT_W'(1);
               if (debug_ready) begin
                  rdata_q <= op_q ? '0 : debug_read_data;
                  err_q   <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt_q != CNT_W'(TIMEOUT)) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               if (debug_ready) begin
                  rdata_q <= op_q ? '0 : debug_read_data;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign debug_addr       = addr_q;
   assign debug_write_data = wdata_q;
   assign rsp_rdata        = rdata_q;
   assign rsp_write        = op_q;
   assign rsp_error        = err_q;

endmodule

// File: tb/tb_debug_host_master.sv
// Directed bench for debug_host_master with a response scoreboard.
// Latency: stimulus driven 1 time unit after posedge, DUT sampled on negedge.
// Backpressure: rsp_ready and debug_ready are driven per test to stall the DUT.
module tb_debug_host_master;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_write;
   logic        rsp_error;
   logic        debug_enable;
   logic [11:0] debug_addr;
   logic        debug_read;
   logic        debug_write;
   logic [31:0] debug_write_data;
   logic [31:0] debug_read_data;
   logic        debug_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 3;   // 1: responder pulses ready rdy_delay cycles after strobe; 3: driven by stimulus
   int rdy_delay = 3;
   int dly = 0;

   typedef struct {
      logic        w;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   debug_host_master dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_write        (cmd_write),
      .cmd_addr         (cmd_addr),
      .cmd_wdata        (cmd_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_rdata        (rsp_rdata),
      .rsp_write        (rsp_write),
      .rsp_error        (rsp_error),
      .debug_enable     (debug_enable),
      .debug_addr       (debug_addr),
      .debug_read       (debug_read),
      .debug_write      (debug_write),
      .debug_write_data (debug_write_data),
      .debug_read_data  (debug_read_data),
      .debug_ready      (debug_ready),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder returns its own address as read data.
   assign debug_read_data = {20'h0, debug_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic w, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.w = w;
      e.rdata = rdata;
      e.err = err;
      exp_q.push_back(e);
   endtask

   // Delayed responder: one ready pulse rdy_delay cycles after the strobe cycle.
   always @(negedge clk) begin
      if (rdy_mode == 1) begin
         if (debug_read || debug_write) begin
            dly = rdy_delay;
            debug_ready = 1'b0;
         end else if (dly > 1) begin
            dly--;
         end else if (dly == 1) begin
            dly = 0;
            debug_ready = 1'b1;
         end else begin
            debug_ready = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every completed response handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rdata %h write %b error %b, expected no response",
                     rsp_rdata, rsp_write, rsp_error);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_write", {31'h0, rsp_write}, {31'h0, mon_e.w});
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_error", {31'h0, rsp_error}, {31'h0, mon_e.err});
         end
      end
   end

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;
      debug_ready = 1'b0;

      // Reset state.
      repeat (3) tick();
      smp();
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_enable", {31'h0, debug_enable}, 32'd0);
      chk("rst_strobes", {30'h0, debug_read, debug_write}, 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_addr", {20'h0, debug_addr}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      tick();
      reset = 1'b0;
      smp();

      // Zero-wait read of 12'h001.
      rdy_mode = 3;
      debug_ready = 1'b1;
      tick();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h001; cmd_wdata = 32'hdead_beef;
      push_exp(1'b0, 32'h0000_0001, 1'b0);
      smp();
      chk("t1_c0_enable", {31'h0, debug_enable}, 32'd0);
      tick();
      cmd_valid = 1'b0;
      smp();
      chk("t1_c1_enable", {31'h0, debug_enable}, 32'd1);
      chk("t1_c1_read", {31'h0, debug_read}, 32'd0);
      tick(); smp();
      chk("t1_c2_read", {31'h0, debug_read}, 32'd1);
      chk("t1_c2_addr", {20'h0, debug_addr}, 32'h001);
      tick(); smp();
      chk("t1_c3_read", {31'h0, debug_read}, 32'd0);
      chk("t1_c3_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      tick(); smp();
      chk("t1_c4_enable", {31'h0, debug_enable}, 32'd0);

      // Write with ready 3 cycles after the strobe.
      debug_ready = 1'b0;
      rdy_mode = 1;
      tick();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h002; cmd_wdata = 32'h1234_5678;
      push_exp(1'b1, 32'h0, 1'b0);
      smp();
      tick();
      cmd_valid = 1'b0;
      smp();
      chk("t2_c1_write", {31'h0, debug_write}, 32'd0);
      tick(); smp();
      chk("t2_c2_write", {31'h0, debug_write}, 32'd1);
      chk("t2_c2_addr", {20'h0, debug_addr}, 32'h002);
      chk("t2_c2_wdata", debug_write_data, 32'h1234_5678);
      for (int k = 1; k <= 3; k++) begin
         tick(); smp();
         chk("t2_wait_write", {31'h0, debug_write}, 32'd0);
         chk("t2_wait_addr", {20'h0, debug_addr}, 32'h002);
         chk("t2_wait_wdata", debug_write_data, 32'h1234_5678);
         chk("t2_wait_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      end
      tick(); smp();
      chk("t2_c6_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      tick(); smp();
      chk("t2_c7_enable", {31'h0, debug_enable}, 32'd0);
      rdy_mode = 3;

      // CSR read with a responder that never readies: timeout.
      tick();
      debug_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h801;
      push_exp(1'b0, 32'h0, 1'b1);
      smp();
      tick();
      cmd_valid = 1'b0;
      smp();
      tick(); smp();
      chk("t3_strobe", {31'h0, debug_read}, 32'd1);
      chk("t3_addr", {20'h0, debug_addr}, 32'h801);
      for (int k = 1; k <= 15; k++) begin
         tick(); smp();
         chk("t3_wait_rsp_valid", {31'h0, rsp_valid}, 32'd0);
         chk("t3_wait_enable", {31'h0, debug_enable}, 32'd1);
      end
      tick(); smp();
      chk("t3_timeout_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      tick(); smp();
      chk("t3_after_enable", {31'h0, debug_enable}, 32'd0);

      // Fill the queue behind a stalled response; ready pulse during RESP is ignored.
      rsp_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cmd_valid = (i < 6);
         cmd_write = 1'b0;
         cmd_addr = 12'h010 + 12'(i);
         debug_ready = (i < 3) || (i == 6);
         if (i < 5) push_exp(1'b0, 32'h10 + 32'(i), 1'b0);
         smp();
         chk("t4_cmd_ready", {31'h0, cmd_ready}, (i < 5) ? 32'd1 : 32'd0);
         if (i >= 3) begin
            chk("t4_stall_rsp_valid", {31'h0, rsp_valid}, 32'd1);
            chk("t4_stall_rdata", rsp_rdata, 32'h10);
            chk("t4_stall_flags", {30'h0, rsp_write, rsp_error}, 32'd0);
            chk("t4_stall_strobes", {30'h0, debug_read, debug_write}, 32'd0);
            chk("t4_stall_busy", {31'h0, busy}, 32'd1);
         end
      end
      for (int j = 0; j <= 8; j++) begin
         tick();
         if (j == 0) begin
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            debug_ready = 1'b1;
         end
         smp();
         chk("t4_b2b_enable", {31'h0, debug_enable}, 32'd1);
         chk("t4_b2b_read", {31'h0, debug_read}, (j % 2 == 1) ? 32'd1 : 32'd0);
         chk("t4_b2b_rsp_valid", {31'h0, rsp_valid}, (j % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick(); smp();
      chk("t4_end_enable", {31'h0, debug_enable}, 32'd0);
      chk("t4_end_busy", {31'h0, busy}, 32'd0);

      // Reset while waiting on the bus, with one more command queued.
      debug_ready = 1'b0;
      tick();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
      smp();
      tick();
      cmd_addr = 12'h021;
      smp();
      tick();
      cmd_valid = 1'b0;
      smp();
      chk("t5_strobe", {31'h0, debug_read}, 32'd1);
      tick(); smp();
      tick();
      reset = 1'b1;
      smp();
      tick(); smp();
      chk("t5_enable", {31'h0, debug_enable}, 32'd0);
      chk("t5_strobes", {30'h0, debug_read, debug_write}, 32'd0);
      chk("t5_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("t5_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      chk("t5_busy", {31'h0, busy}, 32'd0);
      tick();
      reset = 1'b0;
      debug_ready = 1'b1;
      repeat (30) tick();
      smp();
      chk("t5_idle_busy", {31'h0, busy}, 32'd0);
      chk("t5_idle_rsp_valid", {31'h0, rsp_valid}, 32'd0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
